// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I-subset control FSM: fetch/decode/exec/mem/wb sequencing, memory handshakes, sticky trap.
// Optional performance counters are enabled with `define MULTICYCLE_CTRL_PERF_CNT_EN.
module multicycle_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        imem_valid_i,
  input  logic        dmem_ready_i,
  input  logic        branch_taken_i,
  output logic        imem_req_o,
  output logic        ir_we_o,
  output logic [1:0]  imm_sel_o,
  output logic        alu_src_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic        reg_we_o,
  output logic        pc_we_o,
  output logic        pc_src_o,
  output logic        trap_o,
  output logic [1:0]  trap_cause_o,
  output logic [2:0]  state_o
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] instret_cnt_o
`endif
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CL_NONE    = 3'd0,
    CL_OPIMM   = 3'd1,
    CL_OP      = 3'd2,
    CL_LOAD    = 3'd3,
    CL_STORE   = 3'd4,
    CL_BRANCH  = 3'd5,
    CL_ILLEGAL = 3'd6
  } class_e;

  localparam bit                TIMEOUT_EN = (MAX_WAIT != 0);
  localparam int                LIMIT_I    = TIMEOUT_EN ? (MAX_WAIT - 1) : 0;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(LIMIT_I);

  function automatic class_e decode_class(input logic [6:0] opc);
    class_e c;
    case (opc)
      7'b0010011: c = CL_OPIMM;
      7'b0110011: c = CL_OP;
      7'b0000011: c = CL_LOAD;
      7'b0100011: c = CL_STORE;
      7'b1100011: c = CL_BRANCH;
      default:    c = CL_ILLEGAL;
    endcase
    return c;
  endfunction

  state_e            state_q, state_d;
  class_e            class_q, class_d;
  class_e            cur_class_s;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        cause_q, cause_d;

  logic       imem_req_s, ir_we_s, alu_src_s, dmem_req_s, dmem_we_s;
  logic       reg_we_s, pc_we_s, pc_src_s, trap_s;
  logic [1:0] imm_sel_s;
  logic       unused_instr_s;

  assign unused_instr_s = ^instr_i[31:7];

  // State, class, wait-counter and cause registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_FETCH;
      class_q <= CL_NONE;
      wait_q  <= {WAIT_W{1'b0}};
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end

  // The class is only latched at the end of DECODE, so DECODE itself looks at instr_i directly
  always_comb begin
    if (state_q == ST_DECODE) begin
      cur_class_s = decode_class(instr_i[6:0]);
    end else begin
      cur_class_s = class_q;
    end
  end

  // Next-state and raw strobe decode; the wait counter only advances on a stay-and-wait cycle
  always_comb begin
    state_d    = state_q;
    class_d    = class_q;
    cause_d    = cause_q;
    wait_d     = {WAIT_W{1'b0}};
    imem_req_s = 1'b0;
    ir_we_s    = 1'b0;
    dmem_req_s = 1'b0;
    dmem_we_s  = 1'b0;
    reg_we_s   = 1'b0;
    pc_we_s    = 1'b0;
    pc_src_s   = 1'b0;
    trap_s     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req_s = 1'b1;
        if (imem_valid_i) begin
          ir_we_s = 1'b1;
          state_d = ST_DECODE;
        end else if (TIMEOUT_EN && (wait_q == WAIT_LIMIT)) begin
          state_d = ST_TRAP;
          cause_d = 2'd2;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_DECODE: begin
        class_d = cur_class_s;
        if (cur_class_s == CL_ILLEGAL) begin
          state_d = ST_TRAP;
          cause_d = 2'd1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (class_q)
          CL_BRANCH: begin
            pc_we_s  = 1'b1;
            pc_src_s = branch_taken_i;
            state_d  = ST_FETCH;
          end
          CL_OPIMM, CL_OP:   state_d = ST_WB;
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          default: begin
            state_d = ST_TRAP;
            cause_d = 2'd1;
          end
        endcase
      end
      ST_MEM: begin
        dmem_req_s = 1'b1;
        dmem_we_s  = (class_q == CL_STORE);
        if (dmem_ready_i) begin
          if (class_q == CL_STORE) begin
            pc_we_s = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (TIMEOUT_EN && (wait_q == WAIT_LIMIT)) begin
          state_d = ST_TRAP;
          cause_d = 2'd3;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_WB: begin
        reg_we_s = 1'b1;
        pc_we_s  = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_TRAP: begin
        trap_s = 1'b1;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Immediate format and ALU operand select, held from DECODE through WB
  always_comb begin
    imm_sel_s = 2'd0;
    alu_src_s = 1'b0;
    if ((state_q == ST_DECODE) || (state_q == ST_EXEC) ||
        (state_q == ST_MEM) || (state_q == ST_WB)) begin
      case (cur_class_s)
        CL_OPIMM, CL_LOAD: begin
          imm_sel_s = 2'd1;
          alu_src_s = 1'b1;
        end
        CL_STORE: begin
          imm_sel_s = 2'd2;
          alu_src_s = 1'b1;
        end
        CL_BRANCH: begin
          imm_sel_s = 2'd3;
          alu_src_s = 1'b0;
        end
        default: begin
          imm_sel_s = 2'd0;
          alu_src_s = 1'b0;
        end
      endcase
    end else begin
      imm_sel_s = 2'd0;
      alu_src_s = 1'b0;
    end
  end

  // Reset forces every output low in the same cycle, dropping any outstanding request
  always_comb begin
    if (rst_i) begin
      imem_req_o   = 1'b0;
      ir_we_o      = 1'b0;
      imm_sel_o    = 2'd0;
      alu_src_o    = 1'b0;
      dmem_req_o   = 1'b0;
      dmem_we_o    = 1'b0;
      reg_we_o     = 1'b0;
      pc_we_o      = 1'b0;
      pc_src_o     = 1'b0;
      trap_o       = 1'b0;
      trap_cause_o = 2'd0;
      state_o      = 3'd0;
    end else begin
      imem_req_o   = imem_req_s;
      ir_we_o      = ir_we_s;
      imm_sel_o    = imm_sel_s;
      alu_src_o    = alu_src_s;
      dmem_req_o   = dmem_req_s;
      dmem_we_o    = dmem_we_s;
      reg_we_o     = reg_we_s;
      pc_we_o      = pc_we_s;
      pc_src_o     = pc_src_s;
      trap_o       = trap_s;
      trap_cause_o = cause_q;
      state_o      = state_q;
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, instret_cnt_q;

  // Free-running cycle and retire counters, wrapping at 2^32
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_cnt_q   <= 32'd0;
      instret_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_q + 32'd1;
      instret_cnt_q <= instret_cnt_q + (pc_we_s ? 32'd1 : 32'd0);
    end
  end

  // Counter outputs read zero while reset is held
  always_comb begin
    if (rst_i) begin
      cycle_cnt_o   = 32'd0;
      instret_cnt_o = 32'd0;
    end else begin
      cycle_cnt_o   = cycle_cnt_q;
      instret_cnt_o = instret_cnt_q;
    end
  end
`endif

endmodule
